// File: rtl/ysyx_22040632_mul_pkg.sv
// Shared types and helpers for the iterative multiplier.
package ysyx_22040632_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // mul_signed encodings; 2'b01 has no name and behaves like MUL_UU
   localparam logic [1:0] MUL_SS = 2'b11;
   localparam logic [1:0] MUL_SU = 2'b10;
   localparam logic [1:0] MUL_UU = 2'b00;

   // Widest product the negate helper handles (XLEN up to 64)
   localparam int PROD_MAX_W = 128;
   typedef logic [PROD_MAX_W-1:0] prod_t;

   // Two's-complement negate; narrower products are zero-extended in and
   // truncated out, which keeps the low bits exact
   function automatic prod_t neg_prod(prod_t v);
      return ~v + prod_t'(1);
   endfunction

endpackage

// File: rtl/ysyx_22040632_mul_iter_if.sv
// Request/response channel of the iterative multiplier.
// master = requester (EXU), slave = multiplier.
interface ysyx_22040632_mul_iter_if #(
   parameter int XLEN = 64
);
   logic            mul_valid;
   logic            mul_ready;
   logic            flush;
   logic            mulw;
   logic [1:0]      mul_signed;
   logic [XLEN-1:0] multiplicand;
   logic [XLEN-1:0] multiplier;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result_hi;
   logic [XLEN-1:0] result_lo;

   modport master (
      output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
      input  mul_ready, out_valid, result_hi, result_lo
   );

   modport slave (
      input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
      output mul_ready, out_valid, result_hi, result_lo
   );
endinterface

// File: rtl/ysyx_22040632_mul_step.sv
// One shift-add step: acc_nx = acc + ((a_mag * digit) << shamt).
// The digit is BPC bits wide, so the partial product is a sum of BPC
// shifted copies of the multiplicand magnitude.
module ysyx_22040632_mul_step #(
   parameter int XLEN = 64,
   parameter int BPC  = 2,
   parameter int SW   = 7
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   a_mag,
   input  logic [BPC-1:0]    digit,
   input  logic [SW-1:0]     shamt,
   output logic [2*XLEN-1:0] acc_nx
);
   logic [2*XLEN-1:0] a_wide;
   logic [2*XLEN-1:0] pp;

   assign a_wide = {{XLEN{1'b0}}, a_mag};

   // Partial product of the magnitude and the current multiplier digit
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, otherwise paths that skip the assignment infer a latch.
      pp = '0;
      for (int i = 0; i < BPC; i++) begin
         if (digit[i]) pp = pp + (a_wide << i);
      end
   end

   assign acc_nx = acc + (pp << shamt);
endmodule

// File: rtl/ysyx_22040632_mul_iter.sv
// Iterative XLEN x XLEN multiplier, BPC multiplier bits per cycle, with
// valid/ready request and response channels and a flush input.
// Optional: define YSYX_22040632_MUL_EARLY_OUT_EN to finish as soon as the
// remaining multiplier bits are all zero.
module ysyx_22040632_mul_iter
   import ysyx_22040632_mul_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int BPC  = 2,   // 1, 2 or 4
   parameter int WLEN = 32
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_22040632_mul_iter_if.slave bus
);
   localparam int PW = 2 * XLEN;
   localparam int CW = $clog2(XLEN / BPC + 1);
   localparam int SW = $clog2(PW);
   localparam logic [CW-1:0] N_FULL = CW'(XLEN / BPC);
   localparam logic [CW-1:0] N_WORD = CW'(WLEN / BPC);

   state_t          state, state_nx;
   logic [XLEN-1:0] a_mag, b_rem;
   logic [PW-1:0]   acc, acc_nx;
   logic [SW-1:0]   shamt;
   logic [CW-1:0]   count;
   logic            neg, is_w;
   logic [XLEN-1:0] res_hi, res_lo;

   logic            a_signed, b_signed, sign_a, sign_b;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
   logic            last;
   logic [PW-1:0]   prod;
   logic [XLEN-1:0] fin_hi, fin_lo;

   // Operand preparation: word extension, sign detection and magnitude.
   // The most-negative value negates to itself, which read unsigned is 2^(XLEN-1).
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.mul_signed)
         MUL_SS:  begin a_signed = 1'b1; b_signed = 1'b1; end
         MUL_SU:  a_signed = 1'b1;
         MUL_UU:  ;
         default: ;
      endcase
      a_ext = bus.multiplicand;
      b_ext = bus.multiplier;
      if (bus.mulw) begin
         a_ext = {{(XLEN-WLEN){a_signed & bus.multiplicand[WLEN-1]}}, bus.multiplicand[WLEN-1:0]};
         b_ext = {{(XLEN-WLEN){b_signed & bus.multiplier[WLEN-1]}}, bus.multiplier[WLEN-1:0]};
      end
      sign_a = a_signed & a_ext[XLEN-1];
      sign_b = b_signed & b_ext[XLEN-1];
      a_abs  = sign_a ? (~a_ext + XLEN'(1)) : a_ext;
      b_abs  = sign_b ? (~b_ext + XLEN'(1)) : b_ext;
   end

   ysyx_22040632_mul_step #(.XLEN(XLEN), .BPC(BPC), .SW(SW)) u_step (
      .acc    (acc),
      .a_mag  (a_mag),
      .digit  (b_rem[BPC-1:0]),
      .shamt  (shamt),
      .acc_nx (acc_nx)
   );

`ifdef YSYX_22040632_MUL_EARLY_OUT_EN
   assign last = (count == CW'(1)) || ((b_rem >> BPC) == '0);
`else
   assign last = (count == CW'(1));
`endif

   // Sign fix-up and word formatting of the product finishing this cycle
   always_comb begin
      prod = neg ? PW'(neg_prod(prod_t'(acc_nx))) : acc_nx;
      if (is_w) begin
         fin_hi = '0;
         fin_lo = {{(XLEN-WLEN){prod[WLEN-1]}}, prod[WLEN-1:0]};
      end else begin
         fin_hi = prod[PW-1:XLEN];
         fin_lo = prod[XLEN-1:0];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential blocks use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake outputs; flush overrides every transition
   always_comb begin
      state_nx      = state;
      bus.mul_ready = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.mul_ready = 1'b1;
            if (bus.mul_valid) state_nx = BUSY;
         end
         BUSY: if (last) state_nx = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (bus.flush) state_nx = IDLE;
   end

   // Datapath: latch operands on accept, iterate in BUSY, write results last
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are plain registers, not a memory array, so all of them
      // are cleared by reset.
      if (rst) begin
         a_mag  <= '0;
         b_rem  <= '0;
         acc    <= '0;
         shamt  <= '0;
         count  <= '0;
         neg    <= 1'b0;
         is_w   <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
      end else if (!bus.flush) begin
         case (state)
            IDLE: if (bus.mul_valid) begin
               a_mag <= a_abs;
               b_rem <= b_abs;
               acc   <= '0;
               shamt <= '0;
               count <= bus.mulw ? N_WORD : N_FULL;
               neg   <= sign_a ^ sign_b;
               is_w  <= bus.mulw;
            end
            BUSY: begin
               acc   <= acc_nx;
               b_rem <= b_rem >> BPC;
               shamt <= shamt + SW'(BPC);
               count <= count - CW'(1);
               if (last) begin
                  res_hi <= fin_hi;
                  res_lo <= fin_lo;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result_hi = res_hi;
   assign bus.result_lo = res_lo;
endmodule

// File: tb/tb_ysyx_22040632_mul_iter.sv
// Directed bench for ysyx_22040632_mul_iter with a result scoreboard.
// Latency is counted in rising edges, the request-accept edge being edge 1.
module tb_ysyx_22040632_mul_iter;
   import ysyx_22040632_mul_pkg::*;

   localparam int XLEN = 64;
   localparam int BPC  = 2;
   localparam int WLEN = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_22040632_mul_iter_if #(.XLEN(XLEN)) mif ();

   ysyx_22040632_mul_iter #(.XLEN(XLEN), .BPC(BPC), .WLEN(WLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   typedef struct {
      logic [127:0] prod;
      int           lat;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference product from native wide multiplication
   function automatic logic [127:0] model(logic [63:0] a, logic [63:0] b, logic [1:0] sg, logic w);
      logic sa, sb2;
      logic [63:0] aa, bb;
      logic [127:0] ea, eb, p;
      sa  = (sg == 2'b11) || (sg == 2'b10);
      sb2 = (sg == 2'b11);
      aa  = a;
      bb  = b;
      if (w) begin
         aa = {{32{sa & a[31]}}, a[31:0]};
         bb = {{32{sb2 & b[31]}}, b[31:0]};
      end
      ea = {{64{sa & aa[63]}}, aa};
      eb = {{64{sb2 & bb[63]}}, bb};
      p  = ea * eb;
      if (w) return {64'h0, {32{p[31]}}, p[31:0]};
      return p;
   endfunction

   // Expected accept-to-valid latency in edges
   function automatic int exp_lat(logic [63:0] b, logic [1:0] sg, logic w);
      int n;
      n = w ? WLEN / BPC : XLEN / BPC;
`ifdef YSYX_22040632_MUL_EARLY_OUT_EN
      begin
         logic [63:0] bb;
         int d;
         bb = w ? {{32{(sg == 2'b11) & b[31]}}, b[31:0]} : b;
         if ((sg == 2'b11) && bb[63]) bb = -bb;
         d = 1;
         while (d < n && (bb >> (d * BPC)) != 64'h0) d++;
         return d + 1;
      end
`else
      return n + 1;
`endif
   endfunction

   task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg, input logic w);
      @(negedge clk);
      mif.mul_valid    = 1'b1;
      mif.multiplicand = a;
      mif.multiplier   = b;
      mif.mul_signed   = sg;
      mif.mulw         = w;
   endtask

   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                        input logic w, input string tag);
      exp_t e;
      e.prod = model(a, b, sg, w);
      e.lat  = exp_lat(b, sg, w);
      e.tag  = tag;
      sb.push_back(e);
      drive_req(a, b, sg, w);
   endtask

   // Wait for the result, compare with the scoreboard head, optionally hold
   // it in DONE, then consume it with out_ready (and flush if asked)
   task automatic collect(input int hold, input bit flush_done);
      exp_t e;
      int cyc;
      bit got, stable;
      logic [63:0] h0, l0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            mif.mul_valid    = 1'b0;
            mif.multiplicand = {$urandom(), $urandom()};
            mif.multiplier   = {$urandom(), $urandom()};
            mif.mul_signed   = 2'($urandom_range(0, 3));
            mif.mulw         = 1'($urandom_range(0, 1));
         end
         got = mif.out_valid;
      end
      e = sb.pop_front();
      check({e.tag, "/lat"}, 128'(cyc), 128'(e.lat));
      check({e.tag, "/hi"}, 128'(mif.result_hi), 128'(e.prod[127:64]));
      check({e.tag, "/lo"}, 128'(mif.result_lo), 128'(e.prod[63:0]));
      check({e.tag, "/rdy_done"}, 128'(mif.mul_ready), 128'(0));
      if (hold > 0) begin
         h0 = mif.result_hi;
         l0 = mif.result_lo;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable &= mif.out_valid & ~mif.mul_ready &
                      (mif.result_hi == h0) & (mif.result_lo == l0);
         end
         check({e.tag, "/hold"}, 128'(stable), 128'(1));
      end
      mif.out_ready = 1'b1;
      mif.flush     = flush_done;
      @(negedge clk);
      mif.out_ready = 1'b0;
      mif.flush     = 1'b0;
      check({e.tag, "/vld_drop"}, 128'(mif.out_valid), 128'(0));
      check({e.tag, "/rdy_back"}, 128'(mif.mul_ready), 128'(1));
   endtask

   // No result may appear for a while after a dropped or flushed request
   task automatic quiet(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         seen |= mif.out_valid | ~mif.mul_ready;
      end
      check(tag, 128'(seen), 128'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      mif.mul_valid    = 1'b0;
      mif.flush        = 1'b0;
      mif.mulw         = 1'b0;
      mif.mul_signed   = MUL_UU;
      mif.multiplicand = '0;
      mif.multiplier   = '0;
      mif.out_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst/ready", 128'(mif.mul_ready), 128'(1));
      check("rst/valid", 128'(mif.out_valid), 128'(0));
      check("rst/hi",    128'(mif.result_hi), 128'(0));
      check("rst/lo",    128'(mif.result_lo), 128'(0));
      rst = 1'b0;

      // Directed values with hand-computed expectations
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL_UU, 1'b0, "uu_max");
      check("uu_max/const", sb[0].prod, {64'hFFFF_FFFF_FFFF_FFFE, 64'h1});
      collect(0, 1'b0);
      issue(-64'sd3, 64'd7, MUL_SS, 1'b0, "ss_m3x7");
      check("ss_m3x7/const", sb[0].prod, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});
      collect(0, 1'b0);
      issue(-64'sd1, 64'hFFFF_FFFF_FFFF_FFFF, MUL_SU, 1'b0, "su_m1");
      collect(0, 1'b0);
      issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, MUL_SS, 1'b0, "ss_minmin");
      check("ss_minmin/const", sb[0].prod, {64'h4000_0000_0000_0000, 64'h0});
      collect(0, 1'b0);
      issue(64'h1_8000_0000, 64'd2, MUL_SS, 1'b1, "w_x2");
      check("w_x2/const", sb[0].prod, 128'h0);
      collect(0, 1'b0);
      issue(64'h1_8000_0000, 64'd3, MUL_SS, 1'b1, "w_x3");
      check("w_x3/const", sb[0].prod, {64'h0, 64'hFFFF_FFFF_8000_0000});
      collect(0, 1'b0);

      // Mixed modes with random operands, including the 2'b01 encoding
      for (int i = 0; i < 8; i++) begin
         issue({$urandom(), $urandom()}, {$urandom(), $urandom()}, 2'(i), 1'(i / 4), "rnd");
         collect(0, 1'b0);
      end

      // Flush ten cycles into BUSY, then a fresh request
      drive_req(64'd123456789, 64'd987654321, MUL_UU, 1'b0);
      @(negedge clk);
      mif.mul_valid = 1'b0;
      repeat (9) @(negedge clk);
      mif.flush = 1'b1;
      @(negedge clk);
      mif.flush = 1'b0;
      check("flush_busy/valid", 128'(mif.out_valid), 128'(0));
      check("flush_busy/ready", 128'(mif.mul_ready), 128'(1));
      quiet("flush_busy/quiet");
      issue(64'd5, 64'd6, MUL_SS, 1'b0, "5x6_hold");
      check("5x6/const", sb[0].prod, 128'd30);
      collect(5, 1'b0);

      // Flush together with a request in IDLE drops the request
      @(negedge clk);
      mif.mul_valid = 1'b1;
      mif.flush     = 1'b1;
      @(negedge clk);
      mif.mul_valid = 1'b0;
      mif.flush     = 1'b0;
      check("flush_idle/ready", 128'(mif.mul_ready), 128'(1));
      quiet("flush_idle/quiet");

      // Flush together with out_ready in DONE consumes the result
      issue(64'd11, 64'd13, MUL_UU, 1'b0, "flush_done");
      collect(0, 1'b1);

      // Async reset in the middle of BUSY
      drive_req(64'd77, 64'd99, MUL_UU, 1'b0);
      @(negedge clk);
      mif.mul_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid/ready", 128'(mif.mul_ready), 128'(1));
      check("rst_mid/valid", 128'(mif.out_valid), 128'(0));
      check("rst_mid/hi",    128'(mif.result_hi), 128'(0));
      check("rst_mid/lo",    128'(mif.result_lo), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      issue(-64'sd100, 64'd250, MUL_SS, 1'b0, "after_rst");
      collect(0, 1'b0);

      // Zero multiplier (minimum latency when early-out is enabled)
      issue(64'd9, 64'd0, MUL_UU, 1'b0, "b_zero");
      collect(0, 1'b0);
      issue(64'd9, 64'd1, MUL_SS, 1'b1, "b_one_w");
      collect(0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/ysyx_22040632_mul_iter.md
Name: ysyx_22040632_mul_iter

Overview:
Iterative, parametrised integer multiplier for the NPC EXU. It replaces the purely combinational multiplier channel with a valid/ready request side, a valid/ready response side and a flush input. It supports signed×signed, signed×unsigned, unsigned×unsigned and RV64 word (mulw) modes. It retires BPC multiplier bits per cycle using shift-add on magnitudes, then applies a sign fix-up to the 2·XLEN product.

Parameters:
XLEN, 64, operand width; result is 2·XLEN split into hi/lo.
BPC, 2, multiplier bits consumed per cycle; legal values are 1, 2, 4; must divide 32.
WLEN, 32, word width used when mulw=1.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mul_valid  in  1  request valid
mul_ready  out  1  multiplier can accept a request
flush  in  1  cancel any in-flight or held operation
mulw  in  1  word multiply: low WLEN bits of each operand; result_lo = sext(product[WLEN-1:0]), result_hi = 0
mul_signed  in  2  2'b11 s×s, 2'b10 multiplicand signed × multiplier unsigned, 2'b00 u×u, 2'b01 treated as u×u
multiplicand  in  XLEN  operand A
multiplier  in  XLEN  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result_hi  out  XLEN  product[2·XLEN-1:XLEN]
result_lo  out  XLEN  product[XLEN-1:0]

Behaviour:
- Reset (async, rst=1): state=IDLE; mul_ready=1; out_valid=0; result_hi/result_lo=0; counters and accumulators=0.
- FSM states are IDLE, BUSY, DONE.
- IDLE
  - mul_ready=1.
  - On mul_valid & ~flush: latch |A|, |B|, neg = signA ^ signB (sign taken only for signed operands), and mode.
  - Set iteration count to XLEN/BPC, or WLEN/BPC if mulw. Go to BUSY.
- BUSY
  - mul_ready=0.
  - Each cycle: acc += (|A| × B[BPC-1:0]) << shift; B >>= BPC; count--.
  - On the last iteration, write the final value to the result registers: two's-complement negated if neg, and sext-WLEN-formatted if mulw. Then go to DONE.
- DONE
  - out_valid=1; results held stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - No new request is accepted in the same cycle as out_ready (mul_ready=0 in DONE).
- Latency: request handshake at edge T gives out_valid=1 from edge T+N+1, where N = iteration count. For XLEN=64, BPC=2 that is 33 cycles full-width and 17 cycles mulw.
- Flush
  - In any state, flush=1 at an edge forces IDLE.
  - out_valid=0 from that edge; result registers are not cleared.
  - flush with mul_valid in IDLE: request is dropped and mul_ready stays 1.
  - flush with out_ready in DONE: flush wins; the result counts as consumed.
- Sign boundaries
  - Most-negative operand (0x8000…0) is handled as magnitude 2^(XLEN-1) in an XLEN-bit unsigned register.
  - s×s of min×min yields hi=0x4000_0000_0000_0000, lo=0.
  - mulw ignores operand bits [XLEN-1:WLEN]; signedness applies to bit WLEN-1.
- Inputs are sampled only at the handshake edge; later changes have no effect.
- Reset mid-operation aborts immediately; no partial result is ever flagged valid.

Optional Feature:
YSYX_22040632_MUL_EARLY_OUT_EN
- Defined: in BUSY, if the remaining shifted multiplier is zero, finish in that cycle. Fix-up is applied as normal. Minimum latency is 2 cycles (e.g. B=0 or B=1 with BPC≥1).
- Undefined: fixed latency N+1 regardless of operand values.

Decomposition:
- Package ysyx_22040632_mul_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - mul_signed encodings MUL_SS=2'b11, MUL_SU=2'b10, MUL_UU=2'b00;
  - function for two's-complement negate of a 2·XLEN vector.
- One sub-module, ysyx_22040632_mul_step (combinational): given acc, |A|, B-digit and shift, returns the next acc. It isolates the BPC-parametrised partial-product adder.

Test Plan:
- u×u, A=0xFFFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF, BPC=2 -> out_valid at T+33; hi=0xFFFF_FFFF_FFFF_FFFE, lo=0x0000_0000_0000_0001.
- s×s, A=-3, B=7 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFEB.
- s×u, A=-1, B=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0x0000_0000_0000_0001.
- mulw s×s, A=0x1_8000_0000, B=2 -> out_valid at T+17; lo=0x0000_0000_0000_0000, hi=0. Repeat with B=3 -> lo=0xFFFF_FFFF_8000_0000.
- Flush mid-BUSY (cycle 10), then new request 5×6 -> no out_valid for the flushed op; next result lo=30, hi=0. In DONE, hold out_ready=0 for 5 cycles -> out_valid and results stable; mul_ready=0 throughout.
- Async reset asserted mid-BUSY, released, then a request -> outputs 0 and mul_ready=1 immediately on reset; next op correct. With EARLY_OUT_EN, A=9, B=0 -> out_valid at T+2, result 0.
